// File: rtl/audio_system_onchip_mem_arbiter.sv
// Two-port arbiter sharing the single-port on-chip sample memory between the stream engine (p0) and host/DMA (p1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to p0 with a p1 starvation guard.
module audio_system_onchip_mem_arbiter #(
   parameter int ADDR_W   = 13,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   p0_address,
   input  logic [DATA_W/8-1:0] p0_byteenable,
   input  logic                p0_read,
   input  logic                p0_write,
   input  logic [DATA_W-1:0]   p0_writedata,
   output logic                p0_waitrequest,
   output logic [DATA_W-1:0]   p0_readdata,
   output logic                p0_readdatavalid,
   input  logic [ADDR_W-1:0]   p1_address,
   input  logic [DATA_W/8-1:0] p1_byteenable,
   input  logic                p1_read,
   input  logic                p1_write,
   input  logic [DATA_W-1:0]   p1_writedata,
   output logic                p1_waitrequest,
   output logic [DATA_W-1:0]   p1_readdata,
   output logic                p1_readdatavalid,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GRANT0 = 2'd1;
   localparam logic [1:0] GRANT1 = 2'd2;

   logic       req0, req1;
   logic       pick1;
   logic [1:0] state;
   logic       grant0, grant1;
   logic       rd_pend, rd_owner;

   assign req0 = p0_read | p0_write;
   assign req1 = p1_read | p1_write;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant;

   // On a tie the port that did not win last time goes next.
   assign pick1 = ~last_grant;

   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= 1'b1;
      else if (state != IDLE)
         last_grant <= (state == GRANT1);
   end
`else
   localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

   logic [7:0] starve_cnt;

   assign pick1 = (starve_cnt == MAX_WAIT_C);

   always_ff @(posedge clk) begin
      if (reset)
         starve_cnt <= 8'd0;
      else if (req1 & ~grant1) begin
         if (starve_cnt != MAX_WAIT_C)
            starve_cnt <= starve_cnt + 8'd1;
      end else
         starve_cnt <= 8'd0;
   end
`endif

   // Grant is recomputed every cycle; nothing is granted while in reset.
   always_comb begin
      state = IDLE;
      if (!reset) begin
         if (req0 & req1)
            state = pick1 ? GRANT1 : GRANT0;
         else if (req0)
            state = GRANT0;
         else if (req1)
            state = GRANT1;
      end
   end

   assign grant0 = (state == GRANT0);
   assign grant1 = (state == GRANT1);

   assign p0_waitrequest = reset | (req0 & ~grant0);
   assign p1_waitrequest = reset | (req1 & ~grant1);

   assign mem_address    = grant1 ? p1_address    : p0_address;
   assign mem_byteenable = grant1 ? p1_byteenable : p0_byteenable;
   assign mem_writedata  = grant1 ? p1_writedata  : p0_writedata;
   assign mem_chipselect = grant0 | grant1;
   assign mem_write      = (grant0 & p0_write) | (grant1 & p1_write);
   assign mem_clken      = 1'b1;

   // Read return tracking: one outstanding read, data arrives the following cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
      end else begin
         rd_pend <= mem_chipselect & ~mem_write;
         if (mem_chipselect & ~mem_write)
            rd_owner <= grant1;
      end
   end

   assign p0_readdatavalid = ~reset & rd_pend & ~rd_owner;
   assign p1_readdatavalid = ~reset & rd_pend &  rd_owner;
   assign p0_readdata      = mem_readdata;
   assign p1_readdata      = mem_readdata;

endmodule

// File: tb/tb_audio_system_onchip_mem_arbiter.sv
// Directed bench for audio_system_onchip_mem_arbiter with a cycle-level reference model and a behavioural memory.
// Build with ARB_ROUND_ROBIN_EN defined to exercise the round-robin contention case.
module tb_audio_system_onchip_mem_arbiter;

   localparam int ADDR_W   = 13;
   localparam int DATA_W   = 32;
   localparam int BE_W     = 4;
   localparam int MAX_WAIT = 4;
   localparam int DEPTH    = 8192;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [ADDR_W-1:0] p0_address = '0, p1_address = '0;
   logic [BE_W-1:0]   p0_byteenable = 4'hF, p1_byteenable = 4'hF;
   logic              p0_read = 1'b0, p0_write = 1'b0, p1_read = 1'b0, p1_write = 1'b0;
   logic [DATA_W-1:0] p0_writedata = '0, p1_writedata = '0;
   logic              p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
   logic [DATA_W-1:0] p0_readdata, p1_readdata;
   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect, mem_write, mem_clken;
   logic [DATA_W-1:0] mem_writedata, mem_readdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   audio_system_onchip_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk(clk), .reset(reset),
      .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
      .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
      .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
      .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
      .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
      .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
      .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
      .mem_readdata(mem_readdata)
   );

   // Single-port synchronous memory slave, one-cycle read latency.
   logic [DATA_W-1:0] mem [0:DEPTH-1];
   logic [DATA_W-1:0] mem_q = '0;
   logic [DATA_W-1:0] mem_w;
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            mem_w = mem[mem_address];
            for (int b = 0; b < BE_W; b++)
               if (mem_byteenable[b]) mem_w[b*8 +: 8] = mem_writedata[b*8 +: 8];
            mem[mem_address] <= mem_w;
         end else
            mem_q <= mem[mem_address];
      end
   end
   assign mem_readdata = mem_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who must win, what memory holds, which read returns next.
   logic [DATA_W-1:0] shadow [0:DEPTH-1];
   int                p1_waited = 0;
`ifdef ARB_ROUND_ROBIN_EN
   int                last_win = 1;
`endif
   bit                pend = 1'b0;
   int                pend_owner = 0;
   logic [DATA_W-1:0] pend_data = '0;
   int                win;
   bit                r0, r1;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic [BE_W-1:0]   wbe;
   logic              wwr;

   always @(negedge clk) begin
      r0 = p0_read | p0_write;
      r1 = p1_read | p1_write;
      check("m_clken", mem_clken, 1);
      if (reset) begin
         check("m_rst_wait0", p0_waitrequest, 1);
         check("m_rst_wait1", p1_waitrequest, 1);
         check("m_rst_cs", mem_chipselect, 0);
         check("m_rst_rdv0", p0_readdatavalid, 0);
         check("m_rst_rdv1", p1_readdatavalid, 0);
         p1_waited = 0;
         pend = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_win = 1;
`endif
      end else begin
         if (r0 && r1)
`ifdef ARB_ROUND_ROBIN_EN
            win = (last_win == 0) ? 1 : 0;
`else
            win = (p1_waited >= MAX_WAIT) ? 1 : 0;
`endif
         else if (r0) win = 0;
         else if (r1) win = 1;
         else win = -1;

         check("m_wait0", p0_waitrequest, r0 && win != 0);
         check("m_wait1", p1_waitrequest, r1 && win != 1);
         check("m_cs", mem_chipselect, win >= 0);
         check("m_rdv0", p0_readdatavalid, pend && pend_owner == 0);
         check("m_rdv1", p1_readdatavalid, pend && pend_owner == 1);
         if (pend) check("m_rdata", pend_owner == 1 ? p1_readdata : p0_readdata, pend_data);

         pend = 1'b0;
         if (win >= 0) begin
            if (win == 1) begin wa = p1_address; wd = p1_writedata; wbe = p1_byteenable; wwr = p1_write; end
            else          begin wa = p0_address; wd = p0_writedata; wbe = p0_byteenable; wwr = p0_write; end
            check("m_addr", mem_address, wa);
            check("m_be", mem_byteenable, wbe);
            check("m_write", mem_write, wwr);
            if (wwr) begin
               check("m_wdata", mem_writedata, wd);
               for (int b = 0; b < BE_W; b++)
                  if (wbe[b]) shadow[wa][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
               pend = 1'b1;
               pend_owner = win;
               pend_data = shadow[wa];
            end
`ifdef ARB_ROUND_ROBIN_EN
            last_win = win;
`endif
         end
         if (r1 && win != 1) p1_waited++;
         else p1_waited = 0;
      end
   end

   // Directed tasks: entered and left just after a rising edge.
   task automatic p1_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
      p1_address = a; p1_writedata = d; p1_byteenable = be; p1_write = 1'b1;
      @(negedge clk); check("p1_wr_wait", p1_waitrequest, 0);
      @(posedge clk); #1; p1_write = 1'b0;
   endtask

   task automatic p1_rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
      p1_address = a; p1_byteenable = 4'hF; p1_read = 1'b1;
      @(negedge clk); check("p1_rd_wait", p1_waitrequest, 0);
      @(posedge clk); #1; p1_read = 1'b0;
      @(negedge clk);
      check("p1_rd_valid", p1_readdatavalid, 1);
      check("p1_rd_data", p1_readdata, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      int k, p0w, nvalid;
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, p0w, nvalid;
      for (int i = 0; i < DEPTH; i++) begin
         mem[i] = 32'(i * 3);
         shadow[i] = 32'(i * 3);
      end

      // Reset held for three cycles with both ports requesting.
      p0_read = 1'b1; p0_address = 13'd1; p1_read = 1'b1; p1_address = 13'd2;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("rst_wait0", p0_waitrequest, 1);
         check("rst_wait1", p1_waitrequest, 1);
         check("rst_rdv0", p0_readdatavalid, 0);
         check("rst_cs", mem_chipselect, 0);
      end
      @(posedge clk); #1;
      reset = 1'b0; p0_read = 1'b0; p1_read = 1'b0;

      // Single-port write/read including a partial byteenable write.
      p1_wr(13'h1FFF, 32'hDEADBEEF, 4'hF);
      p1_rd(13'h1FFF, 32'hDEADBEEF);
      p1_wr(13'h1FFF, 32'h00001234, 4'h3);
      p1_rd(13'h1FFF, 32'hDEAD1234);

`ifdef ARB_ROUND_ROBIN_EN
      // Both ports read continuously: grants alternate starting with p0.
      p0_address = 13'h10; p1_address = 13'h20; p0_read = 1'b1; p1_read = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("rr_wait0", p0_waitrequest, (c % 2) == 1);
         check("rr_wait1", p1_waitrequest, (c % 2) == 0);
         if (c > 0) begin
            check("rr_rdv0", p0_readdatavalid, (c % 2) == 1);
            check("rr_rdv1", p1_readdatavalid, (c % 2) == 0);
            check("rr_data", mem_readdata, (c % 2) == 1 ? 32'h30 : 32'h60);
         end
         @(posedge clk); #1;
      end
      p0_read = 1'b0; p1_read = 1'b0;
      @(posedge clk); #1;
`else
      // p0 reads continuously; p1 must break through after MAX_WAIT cycles.
      k = 0; p0w = 0;
      p0_address = 13'h5; p0_read = 1'b1; p1_address = 13'h100; p1_read = 1'b1;
      for (int c = 1; c <= 20 && k == 0; c++) begin
         @(negedge clk);
         if (p0_waitrequest) p0w++;
         if (!p1_waitrequest) k = c;
         @(posedge clk); #1;
         if (k != 0) p1_read = 1'b0;
      end
      @(negedge clk);
      if (p0_waitrequest) p0w++;
      check("starve_p1_rdv", p1_readdatavalid, 1);
      check("starve_p1_data", p1_readdata, 32'h300);
      @(posedge clk); #1; p0_read = 1'b0;
      check("starve_grant_cycle", k, 5);
      check("starve_p0_waits", p0w, 1);
      @(posedge clk); #1;
`endif

      // Back-to-back reads of a preloaded pattern.
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         p0_address = 13'(i); p0_read = 1'b1;
         @(negedge clk);
         check("pipe_wait", p0_waitrequest, 0);
         if (i > 0) begin
            if (p0_readdatavalid) nvalid++;
            check("pipe_data", p0_readdata, 32'((i - 1) * 3));
         end
         @(posedge clk); #1;
      end
      p0_read = 1'b0;
      @(negedge clk);
      if (p0_readdatavalid) nvalid++;
      check("pipe_last_data", p0_readdata, 32'd21);
      check("pipe_valid_count", nvalid, 8);
      @(posedge clk); #1;

      // Reset the cycle after a read is accepted: that read never returns.
      p0_address = 13'd3; p0_read = 1'b1;
      @(negedge clk); check("rstrd_accept", p0_waitrequest, 0);
      @(posedge clk); #1; p0_read = 1'b0; reset = 1'b1;
      @(negedge clk); check("rstrd_rdv_in_reset", p0_readdatavalid, 0);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk); check("rstrd_rdv_after", p0_readdatavalid, 0);
      @(posedge clk); #1;

      // First tie after reset goes to p0.
      p0_read = 1'b1; p1_read = 1'b1; p0_address = 13'd9; p1_address = 13'd10;
      @(negedge clk);
      check("tie_wait0", p0_waitrequest, 0);
      check("tie_wait1", p1_waitrequest, 1);
      @(posedge clk); #1; p0_read = 1'b0; p1_read = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
